// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - shared types and constants for the sequential ALU
// Purpose: operation codes, flag bit positions and FSM states used by
//          seq_alu and seq_alu_step.
// Ports:   none (package).
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBC = 4'd3,
    OP_CMP = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_LSL = 4'd8,
    OP_LSR = 4'd9,
    OP_ASR = 4'd10,
    OP_ROL = 4'd11,
    OP_ROR = 4'd12
  } oper_e;

  // Flags vector layout is {V,N,Z,C}
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op >= OP_LSL) && (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/seq_alu_step.sv
// rtl/seq_alu_step.sv - one combinational ALU operation or one shift/rotate bit step
// Purpose: computes a single arithmetic/logic result, or advances a shift or
//          rotate by exactly one bit, together with the resulting flags.
// Ports:
//   oper_i     operation code (seq_alu_pkg::oper_e encoding)
//   a_i, b_i   operands (a_i is the value being shifted for shift ops)
//   flags_i    incoming flags {V,N,Z,C}
//   res_o      result
//   flags_o    resulting flags {V,N,Z,C}
//   res_we_o   result is meaningful and should be written to out
//   flags_we_o flags are meaningful and should be written
module seq_alu_step
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       oper_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       flags_i,
  output logic [WIDTH-1:0] res_o,
  output logic [3:0]       flags_o,
  output logic             res_we_o,
  output logic             flags_we_o
);

  logic             sub_op;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             arith_v;
  logic [WIDTH-1:0] res;
  logic             c_new;
  logic             v_new;

  // Shared adder: every arithmetic op is a + b' + cin
  always_comb begin
    sub_op = (oper_i == OP_SUB) || (oper_i == OP_SBC) || (oper_i == OP_CMP);
    b_eff  = sub_op ? ~b_i : b_i;
    case (oper_i)
      OP_ADC, OP_SBC: cin = flags_i[FLAG_C];
      OP_SUB, OP_CMP: cin = 1'b1;
      default:        cin = 1'b0;
    endcase
    sum     = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    // Overflow: operands agree in sign but the sum does not
    arith_v = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
  end

  always_comb begin
    res        = a_i;
    c_new      = flags_i[FLAG_C];
    v_new      = flags_i[FLAG_V];
    res_we_o   = 1'b1;
    flags_we_o = 1'b1;
    case (oper_i)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        res   = sum[WIDTH-1:0];
        c_new = sum[WIDTH];
        v_new = arith_v;
      end
      OP_CMP: begin
        res      = sum[WIDTH-1:0];
        c_new    = sum[WIDTH];
        v_new    = arith_v;
        res_we_o = 1'b0;
      end
      OP_AND: res = a_i & b_i;
      OP_OR:  res = a_i | b_i;
      OP_XOR: res = a_i ^ b_i;
      OP_LSL: begin
        res   = {a_i[WIDTH-2:0], 1'b0};
        c_new = a_i[WIDTH-1];
      end
      OP_LSR: begin
        res   = {1'b0, a_i[WIDTH-1:1]};
        c_new = a_i[0];
      end
      OP_ASR: begin
        res   = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
        c_new = a_i[0];
      end
      // Rotates go through carry: a WIDTH+1 bit ring
      OP_ROL: begin
        res   = {a_i[WIDTH-2:0], flags_i[FLAG_C]};
        c_new = a_i[WIDTH-1];
      end
      OP_ROR: begin
        res   = {flags_i[FLAG_C], a_i[WIDTH-1:1]};
        c_new = a_i[0];
      end
      default: begin
        res_we_o   = 1'b0;
        flags_we_o = 1'b0;
      end
    endcase
  end

  always_comb begin
    flags_o         = 4'b0000;
    flags_o[FLAG_C] = c_new;
    flags_o[FLAG_Z] = (res == '0);
    flags_o[FLAG_N] = res[WIDTH-1];
    flags_o[FLAG_V] = v_new;
    res_o           = res;
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU with start/busy/done handshake
// Purpose: latches an operation on start, executes it (shifts/rotates one bit
//          per cycle) and registers the result and flags.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   start           request, sampled only when idle
//   oper            operation code (seq_alu_pkg::oper_e encoding)
//   a_in, b_in      operands; b_in[SHAMT_W-1:0] is the shift amount
//   proc_flags_in   current flags {V,N,Z,C}
//   out             registered result
//   proc_flags_out  registered flags {V,N,Z,C}
//   busy            high while an operation is in flight (RUN and DONE)
//   done            one-cycle completion pulse
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       oper,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       proc_flags_in,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       proc_flags_out,
  output logic             busy,
  output logic             done
);

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         fl_q, fl_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [3:0]         flags_out_q, flags_out_d;

  logic [WIDTH-1:0]   step_res;
  logic [3:0]         step_flags;
  logic               step_res_we;
  logic               step_flags_we;
  logic               shift_op;
  logic               last_run;

  seq_alu_step #(.WIDTH(WIDTH)) u_step (
    .oper_i     (op_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .flags_i    (fl_q),
    .res_o      (step_res),
    .flags_o    (step_flags),
    .res_we_o   (step_res_we),
    .flags_we_o (step_flags_we)
  );

  assign shift_op = is_shift(op_q);
  // Count of 0 or 1 means this RUN cycle is the last one
  assign last_run = !shift_op || (cnt_q[SHAMT_W-1:1] == '0);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_run) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy           = (state_q != ST_IDLE);
    done           = (state_q == ST_DONE);
    out            = out_q;
    proc_flags_out = flags_out_q;
  end

  // Datapath next-state
  always_comb begin
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    fl_d        = fl_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    flags_out_d = flags_out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = oper;
          a_d   = a_in;
          b_d   = b_in;
          fl_d  = proc_flags_in;
          cnt_d = b_in[SHAMT_W-1:0];
        end
      end
      ST_RUN: begin
        if (!shift_op) begin
          if (step_res_we)   out_d       = step_res;
          if (step_flags_we) flags_out_d = step_flags;
        end else if (cnt_q == '0) begin
          // Zero-length shift: pass a through, C and V untouched
          out_d               = a_q;
          flags_out_d         = fl_q;
          flags_out_d[FLAG_Z] = (a_q == '0);
          flags_out_d[FLAG_N] = a_q[WIDTH-1];
        end else begin
          a_d   = step_res;
          fl_d  = step_flags;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            out_d       = step_res;
            flags_out_d = step_flags;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      fl_q        <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      flags_out_q <= '0;
    end else begin
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fl_q        <= fl_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      flags_out_q <= flags_out_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] oper;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [3:0] proc_flags_in;
  logic [7:0] out;
  logic [3:0] proc_flags_out;
  logic       busy;
  logic       done;

  int n_tests;
  int n_fail;
  int lat;
  int bcyc;
  int n_done;
  int first_done;

  seq_alu #(.WIDTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .oper           (oper),
    .a_in           (a_in),
    .b_in           (b_in),
    .proc_flags_in  (proc_flags_in),
    .out            (out),
    .proc_flags_out (proc_flags_out),
    .busy           (busy),
    .done           (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle. Returns the edge count from the
  // sampling edge to done high, and the number of cycles busy was seen.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] fl, output int latency, output int busy_cycles);
    oper = op; a_in = a; b_in = b; proc_flags_in = fl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; oper = 4'd0; a_in = ~a; b_in = ~b; proc_flags_in = ~fl;
    latency = 1;
    busy_cycles = 0;
    while (done !== 1'b1 && latency < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk); #1;
      latency++;
    end
    if (busy === 1'b1) busy_cycles++;
    @(posedge clk); #1;
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; oper = 4'd0; a_in = 8'h00; b_in = 8'h00; proc_flags_in = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", out, 8'h00);
    check("reset_flags", proc_flags_out, 4'h0);
    check("reset_busy_done", {busy, done}, 2'b00);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(OP_ADD, 8'hFF, 8'h01, 4'b0000, lat, bcyc);
    check("add_lat", lat, 2);
    check("add_busy_cycles", bcyc, 2);
    check("add_out", out, 8'h00);
    check("add_flags", proc_flags_out, 4'b0011);

    run_op(OP_SUB, 8'h80, 8'h01, 4'b0000, lat, bcyc);
    check("sub_out", out, 8'h7F);
    check("sub_flags", proc_flags_out, 4'b1001);

    run_op(OP_CMP, 8'h05, 8'h05, 4'b0000, lat, bcyc);
    check("cmp_lat", lat, 2);
    check("cmp_out_held", out, 8'h7F);
    check("cmp_flags", proc_flags_out, 4'b0011);

    run_op(OP_ADC, 8'h7F, 8'h00, 4'b0001, lat, bcyc);
    check("adc_out", out, 8'h80);
    check("adc_flags", proc_flags_out, 4'b1100);

    run_op(OP_SBC, 8'h05, 8'h05, 4'b0000, lat, bcyc);
    check("sbc_out", out, 8'hFF);
    check("sbc_flags", proc_flags_out, 4'b0100);

    run_op(OP_AND, 8'hF0, 8'h3C, 4'b1001, lat, bcyc);
    check("and_out", out, 8'h30);
    check("and_flags", proc_flags_out, 4'b1001);

    run_op(4'hF, 8'h12, 8'h34, 4'b0110, lat, bcyc);
    check("undef_lat", lat, 2);
    check("undef_out_held", out, 8'h30);
    check("undef_flags_held", proc_flags_out, 4'b1001);

    run_op(OP_LSL, 8'h81, 8'h03, 4'b0000, lat, bcyc);
    check("lsl3_lat", lat, 4);
    check("lsl3_out", out, 8'h08);
    check("lsl3_flags", proc_flags_out, 4'b0000);

    run_op(OP_LSL, 8'h81, 8'h00, 4'b0001, lat, bcyc);
    check("lsl0_lat", lat, 2);
    check("lsl0_out", out, 8'h81);
    check("lsl0_flags", proc_flags_out, 4'b0101);

    run_op(OP_ROR, 8'h01, 8'h01, 4'b0001, lat, bcyc);
    check("ror_lat", lat, 2);
    check("ror_out", out, 8'h80);
    check("ror_flags", proc_flags_out, 4'b0101);

    run_op(OP_ASR, 8'h90, 8'h02, 4'b0000, lat, bcyc);
    check("asr_lat", lat, 3);
    check("asr_out", out, 8'hE4);
    check("asr_flags", proc_flags_out, 4'b0100);

    // start pulsed while a 5-bit shift is running must be ignored
    oper = OP_LSL; a_in = 8'h0B; b_in = 8'h05; proc_flags_in = 4'b0000; start = 1'b1;
    @(posedge clk); #1;
    n_done = 0; first_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) begin
        oper = OP_ADD; a_in = 8'h01; b_in = 8'h01; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = i + 2;
      end
    end
    check("ign_done_pulses", n_done, 1);
    check("ign_lat", first_done, 6);
    check("ign_out", out, 8'h60);
    check("ign_flags", proc_flags_out, 4'b0001);

    // asynchronous reset in the middle of a shift
    oper = OP_LSL; a_in = 8'hFF; b_in = 8'h05; proc_flags_in = 4'b1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    #3 rst = 1'b1;
    #1;
    check("rst_mid_out", out, 8'h00);
    check("rst_mid_flags", proc_flags_out, 4'h0);
    check("rst_mid_busy_done", {busy, done}, 2'b00);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_stays_idle", {busy, done}, 2'b00);

    run_op(OP_ADD, 8'h02, 8'h03, 4'b0000, lat, bcyc);
    check("post_rst_lat", lat, 2);
    check("post_rst_out", out, 8'h05);
    check("post_rst_flags", proc_flags_out, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the CPU's combinational ALU.
- Adds width generality, N and V flags, multi-bit shifts and rotates through carry, and a start/busy/done handshake.
- Sits between the register file and the flags register in the execute stage.
- Arithmetic and logic ops complete in one execute cycle; shifts and rotates take one cycle per bit.

Parameters:
- WIDTH, 8, operand/result width in bits (power of 2, >= 4).
- SHAMT_W, $clog2(WIDTH), width of the shift-amount field taken from b_in.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- oper  in  4  operation code (package enum).
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B; for shifts/rotates, b_in[SHAMT_W-1:0] is the amount k.
- proc_flags_in  in  4  current flags {V,N,Z,C}, bit positions per package.
- out  out  WIDTH  registered result.
- proc_flags_out  out  4  registered flags.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse, high in DONE.

Behaviour:
- Reset (async, any state):
  - state goes to IDLE; out, proc_flags_out, busy and done all go to 0.
  - Any in-progress op is discarded with no partial result.
- States:
  - IDLE: start=1 latches oper, a_in, b_in, flags and k; goes to RUN.
  - RUN: non-shift op computes and registers out/flags, goes to DONE. Shift/rotate with remaining count > 0 does one bit per edge and decrements the count; goes to DONE on the edge where the count reaches 0. k=0 goes to DONE in one edge with out=a, C unchanged.
  - DONE: done=1 for one cycle; goes to IDLE unconditionally.
- start is ignored outside IDLE. Input changes after latching have no effect.
- Latency, from the edge that samples start to done high:
  - non-shift ops: 2 edges.
  - shifts/rotates: max(k,1)+1 edges.
- out and proc_flags_out hold their values between operations.
- Arithmetic: C = carry out of a + b' + cin.
  - add: b'=b, cin=0.
  - adc: b'=b, cin=C_in.
  - sub, cmp: b'=~b, cin=1.
  - sbc: b'=~b, cin=C_in.
  - V = signed overflow.
- cmp: updates flags only; out holds its previous value.
- and/or/xor: C and V unchanged.
- Shifts and rotates:
  - lsl/lsr: zero fill; C = last bit shifted out.
  - asr: sign fill; C = last bit shifted out.
  - rol/ror: rotate through carry (WIDTH+1-bit ring).
  - All shifts/rotates leave V unchanged.
- Z = (result==0) and N = result[WIDTH-1] for every defined op. For cmp they use the internal difference.
- Undefined oper: out and all flags unchanged; still completes with normal 2-edge latency.

Decomposition:
- Package seq_alu_pkg holds:
  - oper enum: add=0, adc=1, sub=2, sbc=3, cmp=4, and=5, or=6, xor=7, lsl=8, lsr=9, asr=10, rol=11, ror=12.
  - flag bit positions: C=0, Z=1, N=2, V=3.
  - state enum: IDLE, RUN, DONE.
- Sub-module seq_alu_step: combinational, WIDTH-parametrised.
  - Computes one arithmetic/logic result or one single-bit shift/rotate step, with flags.
  - seq_alu instantiates it and owns the FSM, count and registers.

Test Plan (WIDTH=8):
- add a=0xFF b=0x01, start one cycle -> done 2 edges later; out=0x00; C=1 Z=1 N=0 V=0; busy high for 2 cycles.
- sub a=0x80 b=0x01 -> out=0x7F; C=1 V=1 N=0 Z=0. Then cmp a=0x05 b=0x05 -> Z=1 C=1; out stays 0x7F.
- lsl a=0x81 k=3 -> done after 4 edges; out=0x08; C=0. Then lsl k=0 with C_in=1 -> out=0x81 (a), C=1, done after 2 edges.
- ror a=0x01 k=1 C_in=1 -> out=0x80, C=1, N=1. asr a=0x90 k=2 -> out=0xE4, C=0, N=1.
- start pulsed during a k=5 lsl -> ignored; result is the lsl result; exactly one done pulse.
- rst asserted mid-shift (between edges) -> out=0, flags=0, busy=0, done=0 immediately. Next start with add 0x02+0x03 -> out=0x05 after 2 edges.
